// File: rtl/cmp_result_tracker_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg : shared state and result encodings for cmp_result_tracker
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAK = 2'd1,
    S_LOCK   = 2'd2
  } state_e;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_GT   = 2'b01;
  localparam logic [1:0] RES_EQ   = 2'b10;
  localparam logic [1:0] RES_LT   = 2'b11;

  // RES_NONE doubles as the "not one-hot" marker.
  function automatic logic [1:0] res_code(input logic gt, input logic eq, input logic lt);
    logic [1:0] code;
    code = RES_NONE;
    unique case ({gt, eq, lt})
      3'b100:  code = RES_GT;
      3'b010:  code = RES_EQ;
      3'b001:  code = RES_LT;
      default: code = RES_NONE;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_result_tracker_if.sv
// ----------------------------------------------------------------------------
// cmp_result_tracker_if : comparator flag input and tracker status bundle
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface cmp_result_tracker_if #(
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             y0;
  logic             y1;
  logic             y2;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] bad_cnt;
  logic [1:0]       last_res;
  logic             eq_lock;
  logic             streak_hit;
  logic             onehot_err;

  modport master (
    output clear, in_valid, y0, y1, y2,
    input  gt_cnt, eq_cnt, lt_cnt, bad_cnt, last_res, eq_lock, streak_hit, onehot_err
  );

  modport slave (
    input  clear, in_valid, y0, y1, y2,
    output gt_cnt, eq_cnt, lt_cnt, bad_cnt, last_res, eq_lock, streak_hit, onehot_err
  );
endinterface

`default_nettype wire

// File: rtl/cmp_result_tracker_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter : up-counter that holds at all-ones instead of wrapping
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic     [W-1:0]  q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/cmp_result_tracker.sv
// ----------------------------------------------------------------------------
// cmp_result_tracker : tallies comparator outcomes, flags non-one-hot samples
//                      and locks after a run of consecutive a==b results
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  cmp_result_tracker_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_THRESH  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] C_RUN_MAX = '1;

  logic       w_smp;
  logic [1:0] w_code;
  logic       w_good;
  logic       w_gt;
  logic       w_eq;
  logic       w_lt;
  logic       w_bad;

  // clear drops any sample presented on the same edge.
  assign w_smp  = bus.in_valid & ~bus.clear;
  assign w_code = res_code(bus.y0, bus.y1, bus.y2);
  assign w_good = (w_code != RES_NONE);
  assign w_gt   = w_smp & (w_code == RES_GT);
  assign w_eq   = w_smp & (w_code == RES_EQ);
  assign w_lt   = w_smp & (w_code == RES_LT);
  assign w_bad  = w_smp & ~w_good;

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (w_gt),
    .q     (bus.gt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (w_eq),
    .q     (bus.eq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (w_lt),
    .q     (bus.lt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bad_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .inc   (w_bad),
    .q     (bus.bad_cnt)
  );

  logic [1:0] r_last_res;
  logic       r_onehot_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_res   <= RES_NONE;
      r_onehot_err <= 1'b0;
    end else if (bus.clear) begin
      r_last_res   <= RES_NONE;
      r_onehot_err <= 1'b0;
    end else if (w_smp) begin
      if (w_good) begin
        r_last_res <= w_code;
      end else begin
        r_onehot_err <= 1'b1;
      end
    end
  end

  state_e           r_state;
  logic [CNT_W-1:0] r_run;
  logic             r_eq_lock;
  logic             r_streak_hit;
  logic [CNT_W-1:0] w_run_inc;

  assign w_run_inc = r_run + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_run        <= '0;
      r_eq_lock    <= 1'b0;
      r_streak_hit <= 1'b0;
    end else if (bus.clear) begin
      r_state      <= S_IDLE;
      r_run        <= '0;
      r_eq_lock    <= 1'b0;
      r_streak_hit <= 1'b0;
    end else begin
      r_streak_hit <= 1'b0;
      if (w_smp) begin
        case (r_state)
          S_IDLE: begin
            if (w_eq) begin
              r_state <= S_STREAK;
              r_run   <= CNT_W'(1);
            end
          end
          S_STREAK: begin
            if (w_eq) begin
              r_run <= w_run_inc;
              if (w_run_inc == C_THRESH) begin
                r_state      <= S_LOCK;
                r_eq_lock    <= 1'b1;
                r_streak_hit <= 1'b1;
              end
            end else begin
              r_state <= S_IDLE;
              r_run   <= '0;
            end
          end
          S_LOCK: begin
            if (w_eq) begin
              if (r_run != C_RUN_MAX) begin
                r_run <= w_run_inc;
              end
            end else begin
              r_state   <= S_IDLE;
              r_run     <= '0;
              r_eq_lock <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_run     <= '0;
            r_eq_lock <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.last_res   = r_last_res;
  assign bus.onehot_err = r_onehot_err;
  assign bus.eq_lock    = r_eq_lock;
  assign bus.streak_hit = r_streak_hit;

endmodule

`default_nettype wire

// File: tb/tb_cmp_result_tracker.sv
// ----------------------------------------------------------------------------
// tb_cmp_result_tracker : directed + random checks of two tracker configurations
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cmp_result_tracker;

  logic clk;
  logic rst_n;

  cmp_result_tracker_if #(.CNT_W(8)) bus_a ();
  cmp_result_tracker_if #(.CNT_W(2)) bus_b ();

  cmp_result_tracker #(.CNT_W(8), .THRESH(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  cmp_result_tracker #(.CNT_W(2), .THRESH(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: index 0 -> dut_a, 1 -> dut_b; tallies gt/eq/lt/bad.
  int m_cap[2] = '{255, 3};
  int m_thr[2] = '{4, 3};
  int m_cnt[2][4];
  int m_streak[2];
  int m_last[2];
  bit m_err[2];
  bit m_hit[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) m_cnt[k][j] = 0;
      m_streak[k] = 0;
      m_last[k]   = 0;
      m_err[k]    = 1'b0;
      m_hit[k]    = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input bit [2:0] y, input bit clr);
    int ones;
    int idx;
    for (int k = 0; k < 2; k++) begin
      m_hit[k] = 1'b0;
      if (clr) begin
        for (int j = 0; j < 4; j++) m_cnt[k][j] = 0;
        m_streak[k] = 0;
        m_last[k]   = 0;
        m_err[k]    = 1'b0;
      end else if (v) begin
        ones = int'(y[0]) + int'(y[1]) + int'(y[2]);
        if (ones == 1) begin
          idx = y[0] ? 0 : (y[1] ? 1 : 2);
          if (m_cnt[k][idx] < m_cap[k]) m_cnt[k][idx]++;
          m_last[k] = idx + 1;
          if (idx == 1) begin
            m_streak[k]++;
            m_hit[k] = (m_streak[k] == m_thr[k]);
          end else begin
            m_streak[k] = 0;
          end
        end else begin
          if (m_cnt[k][3] < m_cap[k]) m_cnt[k][3]++;
          m_err[k]    = 1'b1;
          m_streak[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    check_val({ph, " a.gt_cnt"},     32'(bus_a.gt_cnt),     32'(m_cnt[0][0]));
    check_val({ph, " a.eq_cnt"},     32'(bus_a.eq_cnt),     32'(m_cnt[0][1]));
    check_val({ph, " a.lt_cnt"},     32'(bus_a.lt_cnt),     32'(m_cnt[0][2]));
    check_val({ph, " a.bad_cnt"},    32'(bus_a.bad_cnt),    32'(m_cnt[0][3]));
    check_val({ph, " a.last_res"},   32'(bus_a.last_res),   32'(m_last[0]));
    check_val({ph, " a.eq_lock"},    32'(bus_a.eq_lock),    32'(m_streak[0] >= m_thr[0]));
    check_val({ph, " a.streak_hit"}, 32'(bus_a.streak_hit), 32'(m_hit[0]));
    check_val({ph, " a.onehot_err"}, 32'(bus_a.onehot_err), 32'(m_err[0]));
    check_val({ph, " b.gt_cnt"},     32'(bus_b.gt_cnt),     32'(m_cnt[1][0]));
    check_val({ph, " b.eq_cnt"},     32'(bus_b.eq_cnt),     32'(m_cnt[1][1]));
    check_val({ph, " b.lt_cnt"},     32'(bus_b.lt_cnt),     32'(m_cnt[1][2]));
    check_val({ph, " b.bad_cnt"},    32'(bus_b.bad_cnt),    32'(m_cnt[1][3]));
    check_val({ph, " b.last_res"},   32'(bus_b.last_res),   32'(m_last[1]));
    check_val({ph, " b.eq_lock"},    32'(bus_b.eq_lock),    32'(m_streak[1] >= m_thr[1]));
    check_val({ph, " b.streak_hit"}, 32'(bus_b.streak_hit), 32'(m_hit[1]));
    check_val({ph, " b.onehot_err"}, 32'(bus_b.onehot_err), 32'(m_err[1]));
  endtask

  // y is {y2,y1,y0}: 3'b001 gt, 3'b010 eq, 3'b100 lt.
  task automatic step(input string ph, input bit v, input bit [2:0] y, input bit clr);
    @(negedge clk);
    bus_a.in_valid = v;  bus_b.in_valid = v;
    bus_a.y0 = y[0];     bus_b.y0 = y[0];
    bus_a.y1 = y[1];     bus_b.y1 = y[1];
    bus_a.y2 = y[2];     bus_b.y2 = y[2];
    bus_a.clear = clr;   bus_b.clear = clr;
    @(posedge clk);
    #1;
    model_step(v, y, clr);
    check_all(ph);
  endtask

  task automatic run_seq(input string ph, input bit [2:0] y, input int n);
    for (int i = 0; i < n; i++) step(ph, 1'b1, y, 1'b0);
  endtask

  initial begin
    int r;
    bit [2:0] ry;
    bit rv;
    bit rc;

    rst_n = 1'b0;
    bus_a.clear = 1'b0; bus_a.in_valid = 1'b0;
    bus_a.y0 = 1'b0; bus_a.y1 = 1'b0; bus_a.y2 = 1'b0;
    bus_b.clear = 1'b0; bus_b.in_valid = 1'b0;
    bus_b.y0 = 1'b0; bus_b.y1 = 1'b0; bus_b.y2 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_seq("gt3", 3'b001, 3);
    check_val("gt3 gt_cnt", 32'(bus_a.gt_cnt), 32'd3);
    check_val("gt3 last_res", 32'(bus_a.last_res), 32'd1);

    step("clr", 1'b0, 3'b000, 1'b1);
    run_seq("eq4", 3'b010, 3);
    check_val("eq3 no hit", 32'(bus_a.streak_hit), 32'd0);
    step("eq4", 1'b1, 3'b010, 1'b0);
    check_val("eq4 hit", 32'(bus_a.streak_hit), 32'd1);
    check_val("eq4 lock", 32'(bus_a.eq_lock), 32'd1);
    step("idle", 1'b0, 3'b010, 1'b0);
    step("eq5", 1'b1, 3'b010, 1'b0);
    check_val("eq5 no repulse", 32'(bus_a.streak_hit), 32'd0);

    step("clr", 1'b0, 3'b000, 1'b1);
    run_seq("brk", 3'b010, 2);
    step("brk", 1'b1, 3'b001, 1'b0);
    run_seq("brk", 3'b010, 3);
    check_val("brk no lock", 32'(bus_a.eq_lock), 32'd0);
    step("brk", 1'b1, 3'b010, 1'b0);
    check_val("brk lock", 32'(bus_a.eq_lock), 32'd1);

    step("bad", 1'b1, 3'b011, 1'b0);
    check_val("bad bad_cnt", 32'(bus_a.bad_cnt), 32'd1);
    check_val("bad err", 32'(bus_a.onehot_err), 32'd1);
    check_val("bad unlock", 32'(bus_a.eq_lock), 32'd0);
    step("bad", 1'b1, 3'b000, 1'b0);
    run_seq("sticky", 3'b100, 5);
    check_val("sticky err", 32'(bus_a.onehot_err), 32'd1);
    check_val("sat b.lt_cnt", 32'(bus_b.lt_cnt), 32'd3);

    step("clrv", 1'b1, 3'b010, 1'b1);
    check_val("clrv eq_cnt", 32'(bus_a.eq_cnt), 32'd0);

    // Async reset while locked: eq_lock must drop before the next clock edge.
    run_seq("lock", 3'b010, 4);
    check_val("pre-rst lock", 32'(bus_a.eq_lock), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 7));
      ry = (r <= 3) ? 3'b010 : (r == 4) ? 3'b001 : (r == 5) ? 3'b100 : 3'($urandom);
      rv = ($urandom_range(0, 4) != 0);
      rc = ($urandom_range(0, 39) == 0);
      step("rand", rv, ry, rc);
    end

    // Long eq run to exercise run-counter saturation in dut_b while locked.
    step("clr", 1'b0, 3'b000, 1'b1);
    run_seq("longeq", 3'b010, 10);
    check_val("longeq b.eq_cnt", 32'(bus_b.eq_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
